// File: rtl/fp_pkg.sv
// fp_pkg: FP32 field widths, exponent limits and operand classes shared by the float<->integer stages.
package fp_pkg;
  localparam int FP_W     = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;
  localparam logic [FP_EXP_W-1:0] EXP_NORM_MIN = 8'h7E;
  localparam logic [FP_EXP_W-1:0] EXP_NORM_MAX = 8'h86;
  localparam logic [FP_EXP_W-1:0] EXP_BIG_MIN  = 8'h87;
  localparam logic [FP_EXP_W-1:0] EXP_SPECIAL  = 8'hFF;
  typedef enum logic [2:0] {
    FP_ZERO,
    FP_TINY,
    FP_NORM,
    FP_BIG,
    FP_INF,
    FP_NAN,
    FP_NEG
  } fp_class_t;
endpackage

// File: rtl/fp_classify.sv
// fp_classify: combinational FP32 unpack into class, biased exponent and mantissa with hidden bit.
module fp_classify
  import fp_pkg::*;
(
  input  logic [FP_W-1:0]     fp,
  output fp_class_t           cls,
  output logic [FP_EXP_W-1:0] e,
  output logic [FP_MAN_W:0]   m
);
  logic                s;
  logic [FP_MAN_W-1:0] f;
  assign s = fp[FP_W-1];
  assign e = fp[FP_W-2:FP_MAN_W];
  assign f = fp[FP_MAN_W-1:0];
  assign m = {1'b1, f};
  // Order matters: zero beats sign (-0.0 is plain zero), NaN beats sign.
  assign cls = (e == '0)                       ? FP_ZERO :
               (e == EXP_SPECIAL && f != '0)   ? FP_NAN  :
               s                               ? FP_NEG  :
               (e == EXP_SPECIAL)              ? FP_INF  :
               (e < EXP_NORM_MIN)              ? FP_TINY :
               (e <= EXP_NORM_MAX)             ? FP_NORM : FP_BIG;
endmodule

// File: rtl/fp2pos_int.sv
// fp2pos_int: two-stage FP32 -> unsigned 8-bit converter with valid/ready, saturation flags and counter.
// Define FP2POS_INT_ROUND_EN for round-to-nearest-even; otherwise the NORM path truncates.
module fp2pos_int
  import fp_pkg::*;
(
  input  logic            iClk,
  input  logic            iRst,
  input  logic [FP_W-1:0] iFP,
  input  logic            iValid,
  output logic            oReady,
  output logic [7:0]      oPosINT,
  output logic            oValid,
  input  logic            iReady,
  output logic            oSat,
  output logic            oNeg,
  output logic [15:0]     oSatCnt,
  input  logic            iSatClr
);
  fp_class_t           c_cls, s1_cls;
  logic [FP_EXP_W-1:0] c_e, s1_e;
  logic [FP_MAN_W:0]   c_m, s1_m;
  logic                s1_valid, s1_load, s2_load, out_xfer;
  logic [4:0]          sh;
  logic [7:0]          ip, norm_int, n_int;
  logic                norm_sat, n_sat, n_neg;
  fp_classify u_classify (.fp(iFP), .cls(c_cls), .e(c_e), .m(c_m));
  assign s2_load  = !oValid || iReady;
  assign s1_load  = !s1_valid || s2_load;
  assign oReady   = s1_load;
  assign out_xfer = oValid && iReady;
  // NORM exponents 7E..86 map to right shifts of 24..16, so 5 bits suffice.
  assign sh = 5'(8'(FP_BIAS + FP_MAN_W) - s1_e);
  assign ip = 8'(s1_m >> sh);
`ifdef FP2POS_INT_ROUND_EN
  logic       guard, sticky, up;
  logic [8:0] rnd;
  assign guard  = |(s1_m & (24'd1 << (sh - 5'd1)));
  assign sticky = |(s1_m & ((24'd1 << (sh - 5'd1)) - 24'd1));
  assign up     = guard && (sticky || ip[0]);
  assign rnd    = {1'b0, ip} + {8'd0, up};
  assign norm_int = rnd[8] ? 8'hFF : rnd[7:0];
  assign norm_sat = rnd[8];
`else
  assign norm_int = ip;
  assign norm_sat = 1'b0;
`endif
  assign n_int = (s1_cls == FP_BIG || s1_cls == FP_INF) ? 8'hFF :
                 (s1_cls == FP_NORM)                    ? norm_int : 8'd0;
  assign n_sat = s1_cls == FP_BIG || s1_cls == FP_INF || (s1_cls == FP_NORM && norm_sat);
  assign n_neg = s1_cls == FP_NEG || s1_cls == FP_NAN;
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s1_valid <= 1'b0;
      s1_cls   <= FP_ZERO;
      s1_e     <= '0;
      s1_m     <= '0;
      oValid   <= 1'b0;
      oPosINT  <= 8'd0;
      oSat     <= 1'b0;
      oNeg     <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid <= iValid;
        if (iValid) begin
          s1_cls <= c_cls;
          s1_e   <= c_e;
          s1_m   <= c_m;
        end
      end
      if (s2_load) begin
        oValid <= s1_valid;
        if (s1_valid) begin
          oPosINT <= n_int;
          oSat    <= n_sat;
          oNeg    <= n_neg;
        end
      end
    end
  end
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) oSatCnt <= 16'd0;
    else if (iSatClr) oSatCnt <= 16'd0;
    else if (out_xfer && oSat && oSatCnt != 16'hFFFF) oSatCnt <= oSatCnt + 16'd1;
  end
endmodule

// File: tb/tb_fp2pos_int.sv
// tb_fp2pos_int: randomized and directed checks of fp2pos_int against an arithmetic reference model.
module tb_fp2pos_int;
  logic        iClk = 1'b0;
  logic        iRst;
  logic [31:0] iFP;
  logic        iValid, iReady, iSatClr;
  logic        oReady, oValid, oSat, oNeg;
  logic [7:0]  oPosINT;
  logic [15:0] oSatCnt;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct packed {logic [7:0] v; logic sat; logic neg;} res_t;

  fp2pos_int dut (
    .iClk(iClk), .iRst(iRst), .iFP(iFP), .iValid(iValid), .oReady(oReady),
    .oPosINT(oPosINT), .oValid(oValid), .iReady(iReady), .oSat(oSat),
    .oNeg(oNeg), .oSatCnt(oSatCnt), .iSatClr(iSatClr)
  );

  always #5 iClk = ~iClk;

  // Value = mantissa * 2^(e-150); integer part and remainder by plain division.
  function automatic res_t model(input logic [31:0] x);
    res_t r;
    int e;
    longint m, p, q, rem;
    r = '0;
    e = int'(x[30:23]);
    m = longint'({1'b1, x[22:0]});
    if (e == 0) r = '0;
    else if (e == 255 && x[22:0] != 0) r.neg = 1'b1;
    else if (x[31]) r.neg = 1'b1;
    else if (e == 255 || e > 134) begin r.v = 8'd255; r.sat = 1'b1; end
    else if (e >= 126) begin
      p = longint'(1) << (150 - e);
      q = m / p;
      rem = m % p;
`ifdef FP2POS_INT_ROUND_EN
      if (2 * rem > p || (2 * rem == p && q % 2 == 1)) q = q + 1;
`endif
      if (q > 255) begin r.v = 8'd255; r.sat = 1'b1; end
      else r.v = 8'(q);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom_range(3))
      0: w = $urandom;
      1: w = {1'b0, 8'(126 + $urandom_range(8)), 23'($urandom)};
      2: w = {1'($urandom), 8'(124 + $urandom_range(12)), 23'($urandom)};
      default: w = {1'b0, 8'(133 + $urandom_range(1)), 7'h7F, 16'($urandom)};
    endcase
    return w;
  endfunction

  task automatic send_one(input logic [31:0] x, output res_t got, output int lat);
    @(negedge iClk);
    iFP = x; iValid = 1'b1; iReady = 1'b1;
    @(posedge iClk); #1;
    iValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 10) begin
      @(posedge iClk); #1;
      lat++;
    end
    got = {oPosINT, oSat, oNeg};
  endtask

  task automatic idle();
    @(negedge iClk);
    iValid = 1'b0; iReady = 1'b1;
    @(posedge iClk); #1;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iValid = 1'b0; iReady = 1'b0; iSatClr = 1'b0; iFP = '0;
    repeat (3) @(posedge iClk);
    @(negedge iClk); iRst = 1'b0;
    #1;
    n_cmp++;
    if ({oValid, oPosINT, oSat, oNeg, oSatCnt, oReady} !== {1'b0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset: got v=%b int=%0d sat=%b neg=%b cnt=%0d rdy=%b required 0/0/0/0/0/1",
               oValid, oPosINT, oSat, oNeg, oSatCnt, oReady);
    end
  endtask

  task automatic test_convert();
    logic [31:0] w [6];
    logic [7:0]  ev [6];
    res_t got;
    int lat;
    w = '{32'h43000000, 32'h3F800000, 32'h00000000, 32'h42FF0000, 32'h3F000000, 32'h3FC00000};
`ifdef FP2POS_INT_ROUND_EN
    ev = '{8'd128, 8'd1, 8'd0, 8'd128, 8'd0, 8'd2};
`else
    ev = '{8'd128, 8'd1, 8'd0, 8'd127, 8'd0, 8'd1};
`endif
    for (int i = 0; i < 6; i++) begin
      send_one(w[i], got, lat);
      n_cmp++;
      if (lat !== 2) begin
        n_err++;
        $display("FAIL convert_latency %h: got %0d cycles required 2", w[i], lat);
      end
      n_cmp++;
      if (got !== {ev[i], 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL convert %h: got %0d/sat%b/neg%b required %0d/sat0/neg0", w[i], got.v, got.sat, got.neg, ev[i]);
      end
    end
    idle();
  endtask

  task automatic test_saturate();
    logic [31:0] w [3];
    logic        es [3];
    res_t got;
    int lat;
    w = '{32'h44000000, 32'h7F800000, 32'h437F8000};
`ifdef FP2POS_INT_ROUND_EN
    es = '{1'b1, 1'b1, 1'b1};
`else
    es = '{1'b1, 1'b1, 1'b0};
`endif
    @(negedge iClk); iSatClr = 1'b1;
    @(posedge iClk); #1;
    iSatClr = 1'b0;
    n_cmp++;
    if (oSatCnt !== 16'd0) begin n_err++; $display("FAIL satcnt_clear: got %0d required 0", oSatCnt); end
    for (int i = 0; i < 3; i++) begin
      send_one(w[i], got, lat);
      n_cmp++;
      if (got !== {8'd255, es[i], 1'b0}) begin
        n_err++;
        $display("FAIL saturate %h: got %0d/sat%b/neg%b required 255/sat%b/neg0", w[i], got.v, got.sat, got.neg, es[i]);
      end
    end
    idle();
    n_cmp++;
    if (oSatCnt !== 16'(2 + int'(es[2]))) begin
      n_err++;
      $display("FAIL satcnt_count: got %0d required %0d", oSatCnt, 2 + int'(es[2]));
    end
    send_one(32'h44000000, got, lat);
    @(negedge iClk); iSatClr = 1'b1; iReady = 1'b1;
    @(posedge iClk); #1;
    n_cmp++;
    if ({oSatCnt, oValid} !== {16'd0, 1'b0}) begin
      n_err++;
      $display("FAIL satcnt_clr_priority: got cnt=%0d v=%b required cnt=0 v=0", oSatCnt, oValid);
    end
    @(negedge iClk); iSatClr = 1'b0;
    send_one(32'h7F800000, got, lat);
    idle();
    n_cmp++;
    if (oSatCnt !== 16'd1) begin n_err++; $display("FAIL satcnt_incr: got %0d required 1", oSatCnt); end
  endtask

  task automatic test_negative();
    logic [31:0] w [3];
    logic        en [3];
    res_t got;
    int lat;
    w  = '{32'hBF800000, 32'h7FC00000, 32'h80000000};
    en = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_one(w[i], got, lat);
      n_cmp++;
      if (got !== {8'd0, 1'b0, en[i]}) begin
        n_err++;
        $display("FAIL negative %h: got %0d/sat%b/neg%b required 0/sat0/neg%b", w[i], got.v, got.sat, got.neg, en[i]);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [20];
    res_t exp_r;
    for (int i = 0; i < 20; i++) w[i] = rand_word();
    for (int c = 0; c < 22; c++) begin
      @(negedge iClk);
      if (c >= 2) begin
        exp_r = model(w[c-2]);
        n_cmp++;
        if (!oValid || {oPosINT, oSat, oNeg} !== exp_r) begin
          n_err++;
          $display("FAIL back_to_back[%0d] %h: got v=%b %0d/%b/%b required v=1 %0d/%b/%b", c - 2, w[c-2],
                   oValid, oPosINT, oSat, oNeg, exp_r.v, exp_r.sat, exp_r.neg);
        end
      end
      iReady = 1'b1;
      iValid = c < 20;
      if (c < 20) iFP = w[c];
      #1;
      if (c < 20) begin
        n_cmp++;
        if (oReady !== 1'b1) begin n_err++; $display("FAIL back_to_back_ready[%0d]: got %b required 1", c, oReady); end
      end
    end
    iValid = 1'b0;
  endtask

  task automatic test_random_stream();
    res_t q[$];
    res_t held, exp_r;
    logic stall, acc;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; stall = 1'b0; held = '0;
    iValid = 1'b0;
    while (got < 100 && cyc < 3000) begin
      @(negedge iClk);
      cyc++;
      if (stall) begin
        n_cmp++;
        if (!oValid || {oPosINT, oSat, oNeg} !== held) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b %0d/%b/%b required v=1 %0d/%b/%b", oValid, oPosINT, oSat, oNeg,
                   held.v, held.sat, held.neg);
        end
      end
      if (!iValid && sent < 100 && $urandom_range(3) != 0) begin
        iFP = rand_word(); iValid = 1'b1;
      end
      iReady = $urandom_range(2) != 0;
      #1;
      if (oValid && iReady) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL stream_extra: got %0d/%b/%b required no output", oPosINT, oSat, oNeg);
        end else begin
          exp_r = q.pop_front();
          if ({oPosINT, oSat, oNeg} !== exp_r) begin
            n_err++;
            $display("FAIL stream[%0d]: got %0d/%b/%b required %0d/%b/%b", got, oPosINT, oSat, oNeg,
                     exp_r.v, exp_r.sat, exp_r.neg);
          end
        end
        got++;
      end
      stall = oValid && !iReady;
      held = {oPosINT, oSat, oNeg};
      acc = iValid && oReady;
      if (acc) begin q.push_back(model(iFP)); sent++; end
      @(posedge iClk); #1;
      if (acc) iValid = 1'b0;
    end
    n_cmp++;
    if (got !== 100) begin n_err++; $display("FAIL stream_count: got %0d outputs required 100", got); end
    iValid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    res_t got;
    int lat;
    send_one(32'h7F800000, got, lat);
    idle();
    @(negedge iClk);
    iReady = 1'b0; iFP = 32'h44000000; iValid = 1'b1;
    @(posedge iClk); #1;
    @(negedge iClk);
    iFP = 32'h3F800000;
    @(posedge iClk); #1;
    iValid = 1'b0;
    n_cmp++;
    if ({oReady, oValid} !== 2'b01) begin
      n_err++;
      $display("FAIL full_stall: got rdy=%b v=%b required rdy=0 v=1", oReady, oValid);
    end
    @(negedge iClk); #2;
    iRst = 1'b1;
    #1;
    n_cmp++;
    if ({oValid, oSatCnt, oReady} !== {1'b0, 16'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_midstream: got v=%b cnt=%0d rdy=%b required v=0 cnt=0 rdy=1", oValid, oSatCnt, oReady);
    end
    @(negedge iClk); iRst = 1'b0;
    send_one(32'h41200000, got, lat);
    n_cmp++;
    if (got !== {8'd10, 1'b0, 1'b0} || lat !== 2) begin
      n_err++;
      $display("FAIL after_reset: got %0d/%b/%b lat %0d required 10/0/0 lat 2", got.v, got.sat, got.neg, lat);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_convert();
    test_saturate();
    test_negative();
    test_back_to_back();
    test_random_stream();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
